// File: rtl/pwm_multi_channel_if.sv
// rtl/pwm_multi_channel_if.sv - configuration write bus for pwm_multi_channel
interface pwm_multi_channel_if #(
   parameter int COUNTER_WIDTH = 16
);
   logic                     cfg_wr_en;
   logic [3:0]               cfg_ch;
   logic [COUNTER_WIDTH-1:0] cfg_period;
   logic [COUNTER_WIDTH-1:0] cfg_duty;
   logic                     cfg_mode;

   modport master (output cfg_wr_en, cfg_ch, cfg_period, cfg_duty, cfg_mode);
   modport slave  (input  cfg_wr_en, cfg_ch, cfg_period, cfg_duty, cfg_mode);
endinterface

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM with shadowed (pending/active) per-channel config
// Define PWM_CENTER_ALIGN_EN to build center-aligned up/down counting selected by cfg_mode.
module pwm_multi_channel #(
   parameter int NUM_CH        = 4,
   parameter int COUNTER_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_CH-1:0]  ch_en,
   pwm_multi_channel_if.slave cfg,
   output logic [NUM_CH-1:0]  pwm_out,
   output logic [NUM_CH-1:0]  period_end
);
   localparam logic [COUNTER_WIDTH-1:0] ONE      = COUNTER_WIDTH'(1);
   localparam logic [4:0]               NUM_CH_W = 5'(NUM_CH);

`ifdef PWM_CENTER_ALIGN_EN
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
`else
   logic unused_cfg_mode;
   assign unused_cfg_mode = cfg.cfg_mode;
`endif

   logic wr_valid;
   assign wr_valid = cfg.cfg_wr_en && ({1'b0, cfg.cfg_ch} < NUM_CH_W);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
      logic [COUNTER_WIDTH-1:0] per_q, per_d;
      logic [COUNTER_WIDTH-1:0] duty_q, duty_d;
      logic [COUNTER_WIDTH-1:0] pper_q, pper_d;
      logic [COUNTER_WIDTH-1:0] pduty_q, pduty_d;
      logic                     pend_q, pend_d;
      logic                     pwm_q, pwm_d;
      logic                     pe_q, pe_d;
      logic                     wrap;
      logic                     wr_hit;
`ifdef PWM_CENTER_ALIGN_EN
      logic                     mode_q, mode_d;
      logic                     pmode_q, pmode_d;
      dir_t                     dir_q, dir_d;
`endif

      assign wr_hit = wr_valid && (cfg.cfg_ch == 4'(i));

      always_comb begin
         cnt_d   = cnt_q;
         per_d   = per_q;
         duty_d  = duty_q;
         pper_d  = pper_q;
         pduty_d = pduty_q;
         pend_d  = pend_q;
         pwm_d   = 1'b0;
         pe_d    = 1'b0;
         wrap    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         mode_d  = mode_q;
         pmode_d = pmode_q;
         dir_d   = dir_q;
`endif
         if (!ch_en[i]) begin
            cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_d = DIR_UP;
`endif
         end else begin
            pwm_d = (per_q != '0) && (cnt_q < duty_q);
            if (per_q <= ONE) begin
               wrap = 1'b1;
            end
`ifdef PWM_CENTER_ALIGN_EN
            else if (mode_q) begin
               // Turning point at P-1 counts as a down step so P=2 yields a 2-cycle period.
               if (dir_q == DIR_DOWN || cnt_q == per_q - ONE) begin
                  dir_d = DIR_DOWN;
                  if (cnt_q == ONE) begin
                     wrap = 1'b1;
                  end else begin
                     cnt_d = cnt_q - ONE;
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
`endif
            else if (cnt_q == per_q - ONE) begin
               wrap = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end

            if (wrap) begin
               cnt_d = '0;
               pe_d  = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
               dir_d = DIR_UP;
`endif
            end
         end

         // Load uses the pending registers as they stood before any same-cycle write.
         if ((wrap || !ch_en[i]) && pend_q) begin
            per_d  = pper_q;
            duty_d = pduty_q;
`ifdef PWM_CENTER_ALIGN_EN
            mode_d = pmode_q;
`endif
            pend_d = 1'b0;
         end

         if (wr_hit) begin
            pper_d  = cfg.cfg_period;
            pduty_d = cfg.cfg_duty;
`ifdef PWM_CENTER_ALIGN_EN
            pmode_d = cfg.cfg_mode;
`endif
            pend_d  = 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q   <= '0;
            per_q   <= '0;
            duty_q  <= '0;
            pper_q  <= '0;
            pduty_q <= '0;
            pend_q  <= 1'b0;
            pwm_q   <= 1'b0;
            pe_q    <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            mode_q  <= 1'b0;
            pmode_q <= 1'b0;
            dir_q   <= DIR_UP;
`endif
         end else begin
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            duty_q  <= duty_d;
            pper_q  <= pper_d;
            pduty_q <= pduty_d;
            pend_q  <= pend_d;
            pwm_q   <= pwm_d;
            pe_q    <= pe_d;
`ifdef PWM_CENTER_ALIGN_EN
            mode_q  <= mode_d;
            pmode_q <= pmode_d;
            dir_q   <= dir_d;
`endif
         end
      end

      assign pwm_out[i]    = pwm_q;
      assign period_end[i] = pe_q;
   end

endmodule

// File: doc/pwm_multi_channel.md
PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent PWM channels, range 1..16.
REQ-002 Parameter COUNTER_WIDTH, default 16: width of the period, duty and counter values.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 ch_en  input  NUM_CH  per-channel run enable.
REQ-006 cfg_wr_en  input  1  config write strobe, one write per cycle.
REQ-007 cfg_ch  input  4  target channel index of the write.
REQ-008 cfg_period  input  COUNTER_WIDTH  period in clk cycles.
REQ-009 cfg_duty  input  COUNTER_WIDTH  high time in clk cycles.
REQ-010 cfg_mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-011 pwm_out  output  NUM_CH  registered PWM outputs.
REQ-012 period_end  output  NUM_CH  one-cycle pulse per channel when its counter wraps to 0.

Function
REQ-013 Each channel SHALL hold an active set (period, duty, mode) and a pending set with a pend flag.
REQ-014 A write with cfg_wr_en=1 and cfg_ch<NUM_CH SHALL load that channel's pending set and set its pend flag; cfg_ch>=NUM_CH SHALL be ignored.
REQ-015 Edge mode, period P>=2: counter sequence 0,1,...,P-1,0; the wrap occurs on the cycle the counter is P-1.
REQ-016 Center mode, P>=2: counter sequence 0,1,...,P-1,P-2,...,1,0 (2*(P-1) cycles); the wrap occurs on the down-count cycle the counter is 1; an up/down direction flag is kept per channel.
REQ-017 pwm_out[i] SHALL equal (counter<duty) of the previous cycle, giving 1-cycle latency; duty=0 gives constant low, duty>=P gives constant high.
REQ-018 P=0 or P=1: counter held at 0; period_end pulses every cycle; pwm_out is low for P=0 and follows REQ-017 for P=1.
REQ-019 At a wrap with pend set, the active set SHALL take the pending set and pend SHALL clear, so the new values govern from counter 0 and no partial period occurs.
REQ-020 Write and wrap in the same cycle: the wrap loads the pending contents from before the write; the new write lands in pending with pend left set.
REQ-021 period_end[i] SHALL be registered and assert in the cycle after the wrap cycle, i.e. the cycle in which the counter reads 0.
REQ-022 ch_en[i]=0: counter=0, direction=up, pwm_out[i]=0 and period_end[i]=0; a pending set SHALL load immediately and pend SHALL clear.
REQ-023 ch_en[i] 0->1: counting SHALL start at 0 in the next cycle; pwm_out follows REQ-017.
REQ-024 Mode changes SHALL take effect only through the active-set load of REQ-019 or REQ-022.
REQ-025 All comparisons SHALL be unsigned at COUNTER_WIDTH; the counter SHALL never exceed P-1.

Reset
REQ-026 rst_n low SHALL asynchronously clear all counters, active and pending sets, pend flags and direction flags (direction=up), and drive pwm_out=0 and period_end=0.
REQ-027 Reset mid-period SHALL discard pending writes; after release, channels run from counter 0 with period=0 (output low) until configured.

Configuration
REQ-028 Macro PWM_CENTER_ALIGN_EN: defined = center mode per REQ-016.
REQ-029 Macro PWM_CENTER_ALIGN_EN: undefined = cfg_mode ignored, mode storage and direction logic not built, all channels edge-aligned.

Verification
REQ-030 ch0 P=10 D=3 edge, ch_en=1 -> pwm_out[0] high 3 of every 10 cycles, period_end[0] every 10 cycles.
REQ-031 ch1 P=10 D=3 running, write D=7 mid-period -> current period keeps 3 high cycles, next period has 7.
REQ-032 ch2 P=6 D=2 center (macro defined) -> counter 0,1,2,3,4,5,4,3,2,1, 10-cycle period, output high 3 cycles.
REQ-033 D=0 -> pwm_out constant 0; D=12 with P=10 -> constant 1; P=0 -> output 0.
REQ-034 Write landing exactly on the wrap cycle -> value applied one period later; cfg_ch=9 with NUM_CH=4 -> no channel changes.
REQ-035 Assert rst_n low mid-period with a write pending -> outputs 0 immediately; after release, output stays low with no pending write applied.
